// File: rtl/param_sorter.sv
// Parametrised load / odd-even transposition sort / stream block: N words of W bits.
// Optional SORTER_DUP_FLAG_EN adds a dup_flag output marking repeats of the previous streamed word.
module param_sorter #(
    parameter  int N    = 4,
    parameter  int W    = 4,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_en,
    input  logic [IDXW-1:0] load_idx,
    input  logic [W-1:0]    load_data,
    input  logic            start,
    input  logic            descend,
    output logic            busy,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            done
`ifdef SORTER_DUP_FLAG_EN
    ,
    output logic            dup_flag
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SORT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] phase_q, phase_d;
    logic [IDXW-1:0] k_q, k_d;
    logic            desc_q, desc_d;
    logic [W-1:0]    entry_q [N];
    logic [W-1:0]    entry_d [N];
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            done_q, done_d;
`ifdef SORTER_DUP_FLAG_EN
    logic            dup_q, dup_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        phase_d     = phase_q;
        k_d         = k_q;
        desc_d      = desc_q;
        entry_d     = entry_q;
        busy_d      = (state_q == S_SORT) || (state_q == S_STREAM);
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = (state_q == S_DONE);
`ifdef SORTER_DUP_FLAG_EN
        dup_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    if (int'(load_idx) < N) entry_d[load_idx] = load_data;
                end else if (start) begin
                    desc_d  = descend;
                    phase_d = '0;
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                // Pairs start at index 0 on even phases and index 1 on odd phases; equal words never swap.
                for (int i = 0; i < N - 1; i++) begin
                    if ((i % 2) == int'(phase_q[0])) begin
                        if (desc_q ? (entry_q[i] < entry_q[i+1]) : (entry_q[i] > entry_q[i+1])) begin
                            entry_d[i]   = entry_q[i+1];
                            entry_d[i+1] = entry_q[i];
                        end
                    end
                end
                phase_d = phase_q + IDXW'(1);
                if (phase_q == LAST) begin
                    phase_d = '0;
                    k_d     = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid_d = 1'b1;
                out_data_d  = entry_q[k_q];
                out_idx_d   = k_q;
`ifdef SORTER_DUP_FLAG_EN
                dup_d       = (k_q != '0) && (entry_q[k_q] == out_data_q);
`endif
                k_d = k_q + IDXW'(1);
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            k_q         <= '0;
            desc_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
`ifdef SORTER_DUP_FLAG_EN
            dup_q       <= 1'b0;
`endif
            // NOTE: the entry array is deliberately reset; a restart after reset must stream zeros.
            for (int i = 0; i < N; i++) entry_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            k_q         <= k_d;
            desc_q      <= desc_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
`ifdef SORTER_DUP_FLAG_EN
            dup_q       <= dup_d;
`endif
            entry_q     <= entry_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;
`ifdef SORTER_DUP_FLAG_EN
    assign dup_flag  = dup_q;
`endif

endmodule

// File: doc/param_sorter.md
Name: param_sorter

Overview:
- Parametrised successor to the fixed 4-entry, 4-bit load/sort/display chain.
- Loads N words of W bits by index and sorts them in place, ascending or descending, with an odd-even transposition network (one phase per cycle).
- Then streams the sorted words out one per cycle with a valid strobe.
- Sits between the input-capture logic and the display/output logic of the top level.

Parameters:
- N, 4, number of entries; legal N >= 2.
- W, 4, data width in bits.
- IDXW (localparam), $clog2(N), index width; not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- load_en  input  1  write strobe for the entry array.
- load_idx  input  IDXW  entry to write.
- load_data  input  W  value to write.
- start  input  1  begin sort-and-stream.
- descend  input  1  0 = ascending, 1 = descending; sampled at start.
- busy  output  1  high in SORT and STREAM.
- out_valid  output  1  out_data/out_idx valid this cycle.
- out_data  output  W  sorted word.
- out_idx  output  IDXW  rank of out_data, 0..N-1.
- done  output  1  one-cycle pulse after the last streamed word.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All entries cleared to 0; state = IDLE; phase/stream counters = 0; latched direction = ascending.
  - busy, out_valid, out_data, out_idx and done all 0.
  - Reset takes priority over every other input in every state, including mid-sort and mid-stream.
- IDLE:
  - load_en = 1 writes load_data to entry[load_idx].
  - A write with load_idx >= N (possible when N is not a power of 2) is ignored.
  - start = 1 with load_en = 0: latch descend, clear the phase counter, go to SORT.
  - start = 1 with load_en = 1 in the same cycle: the load is performed and start is dropped; the state stays IDLE.
- SORT:
  - Exactly N cycles; phase p = 0..N-1.
  - Even p compares pairs (0,1),(2,3),...; odd p compares (1,2),(3,4),....
  - Swap only when strictly out of order for the latched direction. Equal values never swap, so the sort is stable.
  - All compares are unsigned, W bits.
  - After phase N-1: clear the stream counter, go to STREAM.
- STREAM:
  - Exactly N cycles, with k = 0..N-1 on consecutive cycles.
  - Each cycle: out_valid = 1, out_data = entry[k], out_idx = k.
  - After k = N-1: done = 1 for exactly one cycle (out_valid = 0 on that cycle), then return to IDLE.
- Outputs outside STREAM:
  - out_valid = 0; out_data and out_idx hold their last driven values (0 after reset).
- busy is 1 from the first SORT cycle through the last STREAM cycle.
  - The first SORT cycle is the cycle after start is sampled.
  - done asserts the cycle busy falls.
- Latency: with start sampled at edge t, the first out_valid cycle follows edge t+N+1 and done follows edge t+2N+1.
- While busy:
  - load_en and start are ignored.
  - A change on descend has no effect.
- After completion, entries remain in sorted order.
  - A second start without reloading re-sorts them in the newly sampled direction.
- A reset in the middle of an operation aborts it: no partial stream continues and no done pulse is issued.

Optional Feature:
- Macro: SORTER_DUP_FLAG_EN.
- Defined:
  - Adds output port dup_flag (1 bit), registered and aligned with out_valid.
  - dup_flag = 1 when out_valid = 1, k > 0, and out_data equals the word streamed at k-1.
  - dup_flag is 0 otherwise, and resets to 0.
- Not defined: dup_flag port and its compare logic are absent; all other behaviour is identical.

Test Plan:
- N=4, W=4: load 9,3,7,1 at idx 0..3, start with descend=0 -> STREAM emits 1,3,7,9 with out_idx 0..3 on 4 consecutive cycles; done pulses once; busy high for exactly 8 cycles.
- Same load, descend=1 -> 9,7,3,1; then start again with descend=0 and no reload -> 1,3,7,9.
- Load 5,5,2,5 ascending -> 2,5,5,5. With SORTER_DUP_FLAG_EN defined, dup_flag = 0,0,1,1.
- Load 15,0,15,0 (range extremes) -> 0,0,15,15. With N=5, W=8, load 200,17,255,0,17 -> 0,17,17,200,255, and a load at idx 5..7 leaves the entries unchanged.
- start and load_en asserted together -> load performed, busy stays 0; start or load_en pulsed mid-SORT -> entries unchanged, only one stream of 4 words, one done.
- rst_n low during SORT phase 2 -> next cycle busy = 0, out_valid = 0, done = 0, all entries 0; a subsequent start streams 0,0,0,0.
